// File: rtl/sized_datamemory_if.sv
// Request/response bundle for sized_datamemory: the master issues byte/half/word
// loads and stores; the slave returns registered load data and status pulses.
interface sized_datamemory_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req;
    logic                  we;
    logic [1:0]            size;
    logic                  unsignedLd;
    logic [ADDR_WIDTH+1:0] address;
    logic [31:0]           dataIn;
    logic [31:0]           dataOut;
    logic                  valid;
    logic                  misaligned;
    logic                  busy;
    logic                  state;  // FSM debug view: 0 = CLEAR, 1 = READY

    // Handshake: a request is taken on any rising edge where req=1 and busy=0;
    // its outcome (valid for a load, misaligned for a rejected access) is a
    // single-cycle pulse on the following cycle; there is no backpressure.
    modport master (
        output req, we, size, unsignedLd, address, dataIn,
        input  dataOut, valid, misaligned, busy, state
    );
    modport slave (
        input  req, we, size, unsignedLd, address, dataIn,
        output dataOut, valid, misaligned, busy, state
    );
endinterface

// File: rtl/sized_datamemory.sv
// Little-endian 32-bit data memory with byte/half/word access, sign/zero
// extension on sub-word loads and an optional zero-fill sequence after reset.
module sized_datamemory #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sized_datamemory_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [31:0]           mem [DEPTH];

    logic                  clr_we;
    logic                  accept;
    logic                  mis;
    logic                  store_en;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           ld_data;

    // State register; clr_cnt walks the word index while clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (&clr_cnt) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        bus.busy  = (state == CLEAR);
        bus.state = (state == READY);
        clr_we    = (state == CLEAR);
        accept    = (state == READY) && bus.req;
    end

    // Request decode: alignment, lane enables and replicated store data.
    always_comb begin
        word_idx = bus.address[ADDR_WIDTH+1:2];
        lane     = bus.address[1:0];
        mis      = (bus.size == 2'b11)
                || (bus.size == 2'b01 && lane[0])
                || (bus.size == 2'b10 && lane != 2'b00);
        store_en = accept && !mis && bus.we;
        load_en  = accept && !mis && !bus.we;
        be       = 4'b0000;
        wdata    = bus.dataIn;
        case (bus.size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.dataIn[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.dataIn[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.size)
            2'b00:   ld_data = bus.unsignedLd ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_data = bus.unsignedLd ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // Reset suppresses all writes, so a request in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else if (store_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dataOut    <= '0;
            bus.valid      <= 1'b0;
            bus.misaligned <= 1'b0;
        end else begin
            bus.valid      <= load_en;
            bus.misaligned <= accept && mis;
            if (load_en) bus.dataOut <= ld_data;
        end
    end
endmodule
